// File: rtl/bsg_util_link_pkt_arbiter_pkg.sv
// Shared types for the util-link packet arbiter: FSM states and link bundle layout.
// Link bundle is {v, data, ready_and_rev} with ready_and_rev in the LSB.
package bsg_util_link_pkt_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BODY = 2'd1,
    ST_PAD  = 2'd2
  } arb_state_e;

  localparam int unsigned LINK_RDY_BIT = 0;

  function automatic int link_width(input int flit_w);
    return flit_w + 2;
  endfunction

endpackage

// File: rtl/bsg_util_link_pkt_arbiter_rr_pick.sv
// Cyclic priority pick: first eligible requester at or after rr_ptr_i, wrapping.
// Purely combinational, zero latency; no backpressure of its own.
module bsg_util_link_pkt_arbiter_rr_pick #(
  parameter  int num_req_p    = 4,
  localparam int idx_width_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
  input  logic [num_req_p-1:0]    eligible_i,
  input  logic [idx_width_lp-1:0] rr_ptr_i,
  output logic [num_req_p-1:0]    grant_oh_o,
  output logic [idx_width_lp-1:0] grant_idx_o,
  output logic                    grant_v_o
);

  logic [idx_width_lp:0]   w_sum;
  logic [idx_width_lp-1:0] w_idx;

  always_comb begin
    grant_oh_o  = '0;
    grant_idx_o = '0;
    grant_v_o   = 1'b0;
    w_sum       = '0;
    w_idx       = '0;
    for (int i = 0; i < num_req_p; i++) begin
      w_sum = {1'b0, rr_ptr_i} + (idx_width_lp+1)'(i);
      if (w_sum >= (idx_width_lp+1)'(num_req_p)) begin
        w_sum = w_sum - (idx_width_lp+1)'(num_req_p);
      end
      w_idx = w_sum[idx_width_lp-1:0];
      if (!grant_v_o && eligible_i[w_idx]) begin
        grant_v_o         = 1'b1;
        grant_oh_o[w_idx] = 1'b1;
        grant_idx_o       = w_idx;
      end
    end
  end

endmodule

// File: rtl/bsg_util_link_pkt_arbiter.sv
// Packet-atomic round-robin arbiter onto one util-link P port, with stall watchdog padding.
// Zero-latency comb data/ready path; grant held for header + len body flits, ready follows link ready.
module bsg_util_link_pkt_arbiter
  import bsg_util_link_pkt_arbiter_pkg::*;
#(
  parameter  int flit_width_p       = 8,
  parameter  int cord_width_p       = 4,
  parameter  int len_width_p        = 4,
  parameter  int num_req_p          = 4,
  parameter  int stall_limit_p      = 16,
  parameter  int cnt_width_p        = 16,
  localparam int util_link_width_lp = link_width(flit_width_p)
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic [num_req_p-1:0]              req_v_i,
  input  logic [num_req_p*flit_width_p-1:0] req_data_i,
  output logic [num_req_p-1:0]              req_ready_o,
  input  logic [util_link_width_lp-1:0]     link_i,
  output logic [util_link_width_lp-1:0]     link_o,
  input  logic                              clear_i,
  output logic [num_req_p-1:0]              quar_mask_o,
  output logic                              stall_err_o,
  output logic [cnt_width_p-1:0]            pkt_count_o
);

  localparam int idx_width_lp   = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam int stall_width_lp = (stall_limit_p > 0) ? $clog2(stall_limit_p + 1) : 1;

  arb_state_e                r_state;
  logic [idx_width_lp-1:0]   r_rr_ptr;
  logic [idx_width_lp-1:0]   r_grant;
  logic [len_width_p-1:0]    r_body_cnt;
  logic [stall_width_lp-1:0] r_stall_cnt;
  logic [num_req_p-1:0]      r_quar;
  logic                      r_err;
  logic [cnt_width_p-1:0]    r_pkt_cnt;

  logic                      w_out_rdy;
  logic                      w_out_v;
  logic [flit_width_p-1:0]   w_out_dat;
  logic [num_req_p-1:0]      w_req_rdy;
  logic                      w_xfer;
  logic [num_req_p-1:0]      w_pick_oh;
  logic [idx_width_lp-1:0]   w_pick_idx;
  logic                      w_pick_v;
  logic [len_width_p-1:0]    w_hdr_len;
  logic [stall_width_lp-1:0] w_stall_nxt;
  logic                      w_unused_link;

  assign w_out_rdy     = link_i[LINK_RDY_BIT];
  assign w_unused_link = ^link_i[util_link_width_lp-1:1];

  bsg_util_link_pkt_arbiter_rr_pick #(.num_req_p(num_req_p)) u_pick (
    .eligible_i  (req_v_i & ~r_quar),
    .rr_ptr_i    (r_rr_ptr),
    .grant_oh_o  (w_pick_oh),
    .grant_idx_o (w_pick_idx),
    .grant_v_o   (w_pick_v)
  );

  always_comb begin
    w_out_v   = 1'b0;
    w_out_dat = '0;
    w_req_rdy = '0;
    case (r_state)
      ST_IDLE: begin
        w_out_v   = w_pick_v;
        w_out_dat = req_data_i[w_pick_idx*flit_width_p +: flit_width_p];
        w_req_rdy = w_pick_oh & {num_req_p{w_out_rdy}};
      end
      ST_BODY: begin
        w_out_v            = req_v_i[r_grant];
        w_out_dat          = req_data_i[r_grant*flit_width_p +: flit_width_p];
        w_req_rdy[r_grant] = w_out_rdy;
      end
      ST_PAD:  w_out_v = 1'b1;
      default: w_out_v = 1'b0;
    endcase
    // Outputs go quiet for the whole reset assertion, not just after the edge.
    if (!reset_n_i) begin
      w_out_v   = 1'b0;
      w_out_dat = '0;
      w_req_rdy = '0;
    end
  end

  assign w_xfer      = w_out_v & w_out_rdy;
  assign w_hdr_len   = w_out_dat[cord_width_p +: len_width_p];
  assign w_stall_nxt = r_stall_cnt + 1'b1;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_grant     <= '0;
      r_body_cnt  <= '0;
      r_stall_cnt <= '0;
      r_quar      <= '0;
      r_err       <= 1'b0;
      r_pkt_cnt   <= '0;
    end else begin
      if (clear_i) begin
        r_quar <= '0;
        r_err  <= 1'b0;
      end
      case (r_state)
        ST_IDLE: if (w_xfer) begin
          r_grant     <= w_pick_idx;
          r_rr_ptr    <= (w_pick_idx == idx_width_lp'(num_req_p - 1)) ? '0 : w_pick_idx + 1'b1;
          r_stall_cnt <= '0;
          if (w_hdr_len == '0) begin
            r_pkt_cnt <= r_pkt_cnt + 1'b1;
          end else begin
            r_body_cnt <= w_hdr_len;
            r_state    <= ST_BODY;
          end
        end
        ST_BODY: begin
          if (w_xfer) begin
            r_body_cnt  <= r_body_cnt - 1'b1;
            r_stall_cnt <= '0;
            if (r_body_cnt == len_width_p'(1)) begin
              r_state   <= ST_IDLE;
              r_pkt_cnt <= r_pkt_cnt + 1'b1;
            end
          end else if (!req_v_i[r_grant]) begin
            // Only a silent source counts as a stall; link backpressure never does.
            r_stall_cnt <= w_stall_nxt;
            if (stall_limit_p != 0 && w_stall_nxt == stall_width_lp'(stall_limit_p)) begin
              r_state         <= ST_PAD;
              r_quar[r_grant] <= 1'b1;
              r_err           <= 1'b1;
            end
          end
        end
        ST_PAD: if (w_xfer) begin
          r_body_cnt <= r_body_cnt - 1'b1;
          if (r_body_cnt == len_width_p'(1)) begin
            r_state   <= ST_IDLE;
            r_pkt_cnt <= r_pkt_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign link_o      = {w_out_v, w_out_dat, 1'b0};
  assign req_ready_o = w_req_rdy;
  assign quar_mask_o = r_quar;
  assign stall_err_o = r_err;
  assign pkt_count_o = r_pkt_cnt;

endmodule

// File: tb/tb_bsg_util_link_pkt_arbiter.sv
// Bench for the util-link packet arbiter: directed scenarios then random traffic vs a packet-level model.
module tb_bsg_util_link_pkt_arbiter;

  localparam int N   = 4;
  localparam int FW  = 8;
  localparam int LW  = FW + 2;
  localparam int LIM = 4;
  localparam int CW  = 2;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    req_v;
  logic [N*FW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic [LW-1:0]   link_in;
  logic [LW-1:0]   link_out;
  logic            clear;
  logic [N-1:0]    quar;
  logic            err;
  logic [CW-1:0]   cnt;

  always #5 clk = ~clk;

  bsg_util_link_pkt_arbiter #(
    .flit_width_p(FW), .cord_width_p(4), .len_width_p(4),
    .num_req_p(N), .stall_limit_p(LIM), .cnt_width_p(CW)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .req_v_i(req_v), .req_data_i(req_data),
    .req_ready_o(req_ready), .link_i(link_in), .link_o(link_out), .clear_i(clear),
    .quar_mask_o(quar), .stall_err_o(err), .pkt_count_o(cnt)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Packet-level reference: who owns the port, flits left, quiet-cycle run, rr position.
  int           m_owner = -1;
  int           m_left  = 0;
  int           m_quiet = 0;
  int           m_rr    = 0;
  bit           m_pad   = 0;
  logic [N-1:0] m_quar  = '0;
  bit           m_err   = 0;
  int           m_pkts  = 0;
  bit           m_known = 0;

  logic         o_v;
  logic [FW-1:0] o_d;
  logic [N-1:0] o_rdy;

  task automatic step(input logic [N-1:0] v, input logic [N*FW-1:0] d,
                      input bit rdy, input bit clr, input bit rstn);
    int            w;
    bit            ev;
    logic [FW-1:0] ed;
    logic [N-1:0]  er;
    int            len;
    @(negedge clk);
    req_v    = v;
    req_data = d;
    link_in  = {1'b0, {FW{1'b0}}, rdy};
    clear    = clr;
    reset_n  = rstn;
    #1;
    o_v   = link_out[LW-1];
    o_d   = link_out[FW:1];
    o_rdy = req_ready;
    w = -1; ev = 0; ed = '0; er = '0;
    if (!rstn) begin
      ev = 0;
    end else if (m_owner < 0) begin
      for (int i = 0; i < N; i++) begin
        int k = (m_rr + i) % N;
        if (w < 0 && v[k] && !m_quar[k]) w = k;
      end
      if (w >= 0) begin
        ev = 1; ed = d[w*FW +: FW]; er[w] = rdy;
      end
    end else if (m_pad) begin
      ev = 1; ed = '0;
    end else begin
      ev = v[m_owner]; ed = d[m_owner*FW +: FW]; er[m_owner] = rdy;
    end
    chk("link_v", o_v, ev);
    if (ev) chk("link_data", o_d, ed);
    chk("ready", o_rdy, er);
    chk("link_rev", link_out[0], 0);
    if (m_known) begin
      chk("quar", quar, m_quar);
      chk("err", err, m_err);
      chk("pkt_cnt", cnt, m_pkts % (1 << CW));
    end
    if (!rstn) begin
      m_owner = -1; m_left = 0; m_quiet = 0; m_rr = 0; m_pad = 0;
      m_quar = '0; m_err = 0; m_pkts = 0; m_known = 1;
    end else begin
      if (clr) begin m_quar = '0; m_err = 0; end
      if (m_owner < 0) begin
        if (ev && rdy) begin
          m_rr = (w + 1) % N;
          len  = ed[7:4];
          if (len == 0) m_pkts++;
          else begin m_owner = w; m_left = len; m_quiet = 0; end
        end
      end else if (m_pad) begin
        if (ev && rdy) begin
          m_left--;
          if (m_left == 0) begin m_owner = -1; m_pad = 0; m_pkts++; end
        end
      end else if (ev && rdy) begin
        m_left--; m_quiet = 0;
        if (m_left == 0) begin m_owner = -1; m_pkts++; end
      end else if (!v[m_owner]) begin
        m_quiet++;
        if (m_quiet == LIM) begin m_pad = 1; m_quar[m_owner] = 1'b1; m_err = 1; end
      end
    end
  endtask

  task automatic do_reset();
    step('0, '0, 1, 0, 0);
  endtask

  initial begin
    logic [FW-1:0] t2f [4];
    logic [FW-1:0] t3f [3];
    int            idx;
    logic [N-1:0]  rv;
    logic [N*FW-1:0] rd;
    logic [3:0]    ln;
    int            pv, pr;

    reset_n = 0; req_v = '0; req_data = '0; link_in = '0; clear = 0;
    do_reset();
    do_reset();
    step('0, '0, 1, 0, 1);
    chk("rst_quar", quar, 0);
    chk("rst_err", err, 0);
    chk("rst_cnt", cnt, 0);

    // Two zero-length headers from src0 and src2 go out back to back.
    step(4'b0101, {8'h00, 8'h03, 8'h00, 8'h01}, 1, 0, 1);
    chk("t1_first", o_d, 8'h01);
    step(4'b0100, {8'h00, 8'h03, 8'h00, 8'h01}, 1, 0, 1);
    chk("t1_second", o_d, 8'h03);
    step('0, '0, 1, 0, 1);
    chk("t1_cnt", cnt, 2);

    // Src1 packet stays contiguous while src0 waits.
    do_reset();
    t2f = '{8'h31, 8'hA1, 8'hA2, 8'hA3};
    for (int i = 0; i < 4; i++) begin
      step((i == 0) ? 4'b0010 : 4'b0011, {16'h0, t2f[i], 8'h02}, 1, 0, 1);
      chk("t2_flit", o_d, t2f[i]);
    end
    step(4'b0001, {24'h0, 8'h02}, 1, 0, 1);
    chk("t2_src0", o_d, 8'h02);
    step('0, '0, 1, 0, 1);
    chk("t2_cnt", cnt, 2);

    // Toggling link ready: flits arrive once each, in order, with no stall.
    do_reset();
    t3f = '{8'h22, 8'hB1, 8'hB2};
    idx = 0;
    for (int c = 0; c < 12 && idx < 3; c++) begin
      step(4'b0100, {8'h00, t3f[idx], 16'h0}, (c % 2) == 0, 0, 1);
      if (o_v && o_rdy[2]) begin
        chk("t3_flit", o_d, t3f[idx]);
        idx++;
      end
    end
    chk("t3_done", idx, 3);
    step('0, '0, 1, 0, 1);
    chk("t3_cnt", cnt, 1);
    chk("t3_err", err, 0);

    // Src3 abandons its packet; the rest is padded and src3 is quarantined.
    do_reset();
    step(4'b1000, {8'h33, 24'h0}, 1, 0, 1);
    step(4'b1000, {8'hC1, 24'h0}, 1, 0, 1);
    repeat (LIM) step('0, '0, 1, 0, 1);
    step('0, '0, 1, 0, 1);
    chk("t4_quar", quar, 4'b1000);
    chk("t4_err", err, 1);
    chk("t4_pad1", {o_v, o_d}, 9'h100);
    step('0, '0, 1, 0, 1);
    chk("t4_pad2", {o_v, o_d}, 9'h100);
    step(4'b1000, {8'h05, 24'h0}, 1, 0, 1);
    chk("t4_ignored", o_v, 0);
    step(4'b1000, {8'h05, 24'h0}, 1, 1, 1);
    step(4'b1000, {8'h05, 24'h0}, 1, 0, 1);
    chk("t4_restored", {o_v, o_d}, 9'h105);
    chk("t4_clr_err", err, 0);

    // Everyone busy with zero-length packets: strict rotation, counter wraps.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(4'hF, {8'h03, 8'h02, 8'h01, 8'h00}, 1, 0, 1);
      chk("t5_grant", o_rdy, 1 << (i % 4));
      if (i == 4) chk("t5_wrap", cnt, 0);
    end
    step('0, '0, 1, 0, 1);
    chk("t5_cnt", cnt, 1);

    // Reset in the middle of a body.
    do_reset();
    step(4'b0010, {16'h0, 8'h31, 8'h0}, 1, 0, 1);
    step(4'b0010, {16'h0, 8'hD1, 8'h0}, 1, 0, 1);
    step(4'b0010, {16'h0, 8'hD2, 8'h0}, 1, 0, 0);
    chk("t6_v_rst", o_v, 0);
    chk("t6_rdy_rst", o_rdy, 0);
    step(4'b0110, {8'h0, 8'h02, 8'h01, 8'h0}, 1, 0, 1);
    chk("t6_grant", o_rdy, 4'b0010);
    chk("t6_data", o_d, 8'h01);

    // Random traffic in phases of differing source activity and link backpressure.
    for (int c = 0; c < 4000; c++) begin
      pv = ((c / 500) % 2 == 1) ? 35 : 85;
      pr = ((c / 500) % 3 == 0) ? 95 : 60;
      for (int k = 0; k < N; k++) begin
        rv[k] = ($urandom_range(0, 99) < pv);
        ln = ($urandom_range(0, 9) < 7) ? 4'($urandom_range(0, 2)) : 4'($urandom_range(3, 7));
        rd[k*FW +: FW] = {ln, 4'($urandom_range(0, 15))};
      end
      step(rv, rd, $urandom_range(0, 99) < pr, $urandom_range(0, 99) < 3,
           $urandom_range(0, 999) >= 3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
